// File: rtl/espic_irq_dispatch.sv
// Per-node interrupt dispatcher for the ESPIC generator outputs.
// The three ESPIC sources are synchronized and edge-detected, then latched
// as sticky pending bits. The highest-priority pending bit is presented to
// the node CPU through a req/ack/eoi handshake. An ack timeout abandons the
// request and raises a sticky error flag.
module espic_irq_dispatch #(
  parameter int unsigned NODE_ID     = 0,
  parameter int unsigned ACK_TIMEOUT = 1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       irq0_in,
  input  logic [1:0] irq1_mutex_in,
  input  logic       irq2_in,
  input  logic       irq_ack,
  input  logic       irq_eoi,
  output logic       irq_req,
  output logic [1:0] irq_vec,
  output logic [2:0] pending,
  output logic [2:0] in_service,
  output logic       overflow,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERVICE
  } state_t;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(ACK_TIMEOUT);

  state_t      state;
  state_t      state_n;

  logic [2:0]  raw_in;
  logic [2:0]  sync1;
  logic [2:0]  sync2;
  logic [2:0]  sync3;
  logic [2:0]  edge_det;

  logic [15:0] wait_cnt;
  logic [15:0] wait_cnt_n;
  logic [15:0] wait_inc;
  logic [2:0]  vec_onehot;
  logic [2:0]  clr;
  logic [2:0]  pending_n;
  logic [2:0]  in_service_n;
  logic [1:0]  vec_n;
  logic        overflow_n;
  logic        timeout_err_n;

  // Only this node's mutex bit is selected; masking keeps both input bits in use.
  assign raw_in   = {irq2_in, |(irq1_mutex_in & (2'b01 << NODE_ID)), irq0_in};
  assign edge_det = sync2 & ~sync3;
  assign irq_req  = (state == ST_REQ);

  // Two-flop synchronizer plus history flop for rising-edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state, pending update and handshake bookkeeping.
  always_comb begin
    state_n       = state;
    vec_n         = irq_vec;
    wait_cnt_n    = wait_cnt;
    in_service_n  = in_service;
    timeout_err_n = timeout_err;
    wait_inc      = wait_cnt + 16'd1;
    vec_onehot    = 3'b001 << irq_vec;
    clr           = '0;

    if (state == ST_REQ && irq_ack) begin
      clr = vec_onehot;
    end

    // A new edge wins over a same-cycle clear and is then not an overflow.
    pending_n  = (pending & ~clr) | edge_det;
    overflow_n = |(edge_det & pending & ~clr);

    case (state)
      ST_IDLE: begin
        if (|pending) begin
          state_n    = ST_REQ;
          wait_cnt_n = '0;
          if (pending[0]) begin
            vec_n = 2'd0;
          end else if (pending[1]) begin
            vec_n = 2'd1;
          end else begin
            vec_n = 2'd2;
          end
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          in_service_n = vec_onehot;
          state_n      = ST_SERVICE;
        end else begin
          wait_cnt_n = wait_inc;
          if (wait_inc == TIMEOUT_LIMIT) begin
            timeout_err_n = 1'b1;
            state_n       = ST_IDLE;
          end
        end
      end
      ST_SERVICE: begin
        if (irq_eoi) begin
          in_service_n = '0;
          state_n      = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Datapath registers driven by the next-state logic.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      irq_vec     <= '0;
      wait_cnt    <= '0;
      pending     <= '0;
      in_service  <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      irq_vec     <= vec_n;
      wait_cnt    <= wait_cnt_n;
      pending     <= pending_n;
      in_service  <= in_service_n;
      overflow    <= overflow_n;
      timeout_err <= timeout_err_n;
    end
  end

endmodule

// File: tb/tb_espic_irq_dispatch.sv
// Self-checking bench for espic_irq_dispatch: a cycle-level model of the
// dispatcher rules checked every cycle, plus directed literal checkpoints.
module tb_espic_irq_dispatch;

  localparam int unsigned NODE = 1;
  localparam int unsigned TMO  = 8;

  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_SVC  = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       irq0_in = 1'b0;
  logic [1:0] irq1_mutex_in = 2'b00;
  logic       irq2_in = 1'b0;
  logic       irq_ack = 1'b0;
  logic       irq_eoi = 1'b0;
  logic       irq_req;
  logic [1:0] irq_vec;
  logic [2:0] pending;
  logic [2:0] in_service;
  logic       overflow;
  logic       timeout_err;

  int total = 0;
  int bad   = 0;

  espic_irq_dispatch #(
    .NODE_ID     (NODE),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .irq0_in       (irq0_in),
    .irq1_mutex_in (irq1_mutex_in),
    .irq2_in       (irq2_in),
    .irq_ack       (irq_ack),
    .irq_eoi       (irq_eoi),
    .irq_req       (irq_req),
    .irq_vec       (irq_vec),
    .pending       (pending),
    .in_service    (in_service),
    .overflow      (overflow),
    .timeout_err   (timeout_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_mode;
  int         m_vec;
  int         m_wait;
  int         cyc;
  logic [2:0] m_pend;
  logic [2:0] m_insvc;
  logic       m_ovf;
  logic       m_terr;
  logic [2:0] lg [0:4095];
  logic [2:0] e;
  logic [2:0] old2;
  logic [2:0] old3;
  logic [2:0] mclr;
  logic [2:0] n_pend;
  logic       n_ovf;

  always @(negedge CLK) begin
    if (RST) begin
      m_mode = M_IDLE; m_vec = 0; m_wait = 0; cyc = 0;
      m_pend = '0; m_insvc = '0; m_ovf = 1'b0; m_terr = 1'b0;
      chk("rst_req", irq_req, 0);
      chk("rst_vec", irq_vec, 0);
      chk("rst_pend", pending, 0);
      chk("rst_insvc", in_service, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_terr", timeout_err, 0);
    end else begin
      chk("m_req", irq_req, (m_mode == M_REQ) ? 1 : 0);
      if (m_mode == M_REQ) chk("m_vec", irq_vec, m_vec);
      chk("m_pend", pending, m_pend);
      chk("m_insvc", in_service, m_insvc);
      chk("m_ovf", overflow, m_ovf);
      chk("m_terr", timeout_err, m_terr);

      // A source event is seen two cycles after the input goes from low to high.
      lg[cyc] = {irq2_in, irq1_mutex_in[NODE], irq0_in};
      old2 = (cyc >= 2) ? lg[cyc-2] : 3'b000;
      old3 = (cyc >= 3) ? lg[cyc-3] : 3'b000;
      e = old2 & ~old3;

      mclr   = (m_mode == M_REQ && irq_ack) ? (3'b001 << m_vec) : 3'b000;
      n_pend = (m_pend & ~mclr) | e;
      n_ovf  = |(e & m_pend & ~mclr);

      if (m_mode == M_IDLE) begin
        if (m_pend != 0) begin
          for (int i = 2; i >= 0; i--) if (m_pend[i]) m_vec = i;
          m_wait = 0;
          m_mode = M_REQ;
        end
      end else if (m_mode == M_REQ) begin
        if (irq_ack) begin
          m_insvc = 3'b001 << m_vec;
          m_mode  = M_SVC;
        end else begin
          m_wait++;
          if (m_wait == TMO) begin
            m_terr = 1'b1;
            m_mode = M_IDLE;
          end
        end
      end else begin
        if (irq_eoi) begin
          m_insvc = '0;
          m_mode  = M_IDLE;
        end
      end
      m_pend = n_pend;
      m_ovf  = n_ovf;
      if (cyc < 4095) cyc++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    step(2);
    chk("reset_req", irq_req, 0);
    chk("reset_pend", pending, 0);
    chk("reset_terr", timeout_err, 0);
    RST = 1'b0;
    step(3);

    // Single IRQ2
    irq2_in = 1'b1;
    step(3);
    chk("t1_pend", pending, 3'b100);
    chk("t1_req_early", irq_req, 0);
    step(1);
    chk("t1_req", irq_req, 1);
    chk("t1_vec", irq_vec, 2);
    step(1);
    irq2_in = 1'b0;
    step(5);
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    chk("t1_pend_clr", pending, 0);
    chk("t1_insvc", in_service, 3'b100);
    chk("t1_req_drop", irq_req, 0);
    step(9);
    irq_eoi = 1'b1;
    step(1);
    irq_eoi = 1'b0;
    chk("t1_insvc_clr", in_service, 0);
    step(5);
    chk("t1_no_req", irq_req, 0);

    // Priority IRQ0 over IRQ2
    irq0_in = 1'b1; irq2_in = 1'b1;
    step(2);
    irq0_in = 1'b0; irq2_in = 1'b0;
    step(2);
    chk("t2_req", irq_req, 1);
    chk("t2_vec0", irq_vec, 0);
    chk("t2_pend", pending, 3'b101);
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    chk("t2_insvc", in_service, 3'b001);
    chk("t2_pend_left", pending, 3'b100);
    step(1);
    irq_eoi = 1'b1;
    step(1);
    irq_eoi = 1'b0;
    chk("t2_gap", irq_req, 0);
    step(1);
    chk("t2_req2", irq_req, 1);
    chk("t2_vec2", irq_vec, 2);
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    irq_eoi = 1'b1;
    step(1);
    irq_eoi = 1'b0;
    step(4);

    // Node select: only bit NODE of the mutex bus counts
    irq1_mutex_in = 2'b01;
    step(3);
    irq1_mutex_in = 2'b00;
    step(3);
    chk("t3_other_pend", pending, 0);
    chk("t3_other_req", irq_req, 0);
    irq1_mutex_in = 2'b10;
    step(2);
    irq1_mutex_in = 2'b00;
    step(1);
    chk("t3_pend", pending, 3'b010);
    step(1);
    chk("t3_req", irq_req, 1);
    chk("t3_vec", irq_vec, 1);
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    irq_eoi = 1'b1;
    step(1);
    irq_eoi = 1'b0;
    step(3);

    // Overflow: second IRQ0 edge while pending and unacknowledged
    irq0_in = 1'b1;
    step(2);
    irq0_in = 1'b0;
    step(2);
    chk("t4_req", irq_req, 1);
    irq0_in = 1'b1;
    step(2);
    irq0_in = 1'b0;
    chk("t4_ovf_before", overflow, 0);
    step(1);
    chk("t4_ovf", overflow, 1);
    chk("t4_pend", pending, 3'b001);
    step(1);
    chk("t4_ovf_after", overflow, 0);
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    chk("t4_insvc", in_service, 3'b001);
    irq_eoi = 1'b1;
    step(1);
    irq_eoi = 1'b0;
    step(3);

    // IRQ0 edge coinciding with IRQ0 ack: set wins, no overflow
    irq0_in = 1'b1;
    step(2);
    irq0_in = 1'b0;
    step(2);
    irq0_in = 1'b1;
    step(2);
    irq0_in = 1'b0;
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    chk("t5_pend_kept", pending, 3'b001);
    chk("t5_no_ovf", overflow, 0);
    chk("t5_insvc", in_service, 3'b001);
    step(1);
    chk("t5_no_ovf2", overflow, 0);
    irq_eoi = 1'b1;
    step(1);
    irq_eoi = 1'b0;
    step(1);
    chk("t5_rereq", irq_req, 1);
    chk("t5_vec", irq_vec, 0);
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    irq_eoi = 1'b1;
    step(1);
    irq_eoi = 1'b0;
    step(3);

    // Acknowledge timeout
    irq1_mutex_in = 2'b10;
    step(2);
    irq1_mutex_in = 2'b00;
    step(2);
    chk("t6_req_first", irq_req, 1);
    step(7);
    chk("t6_req_last", irq_req, 1);
    chk("t6_terr_pre", timeout_err, 0);
    step(1);
    chk("t6_req_drop", irq_req, 0);
    chk("t6_terr", timeout_err, 1);
    chk("t6_pend_kept", pending, 3'b010);
    step(1);
    chk("t6_rereq", irq_req, 1);
    chk("t6_vec", irq_vec, 1);
    // ack and eoi together: ack only
    irq_ack = 1'b1; irq_eoi = 1'b1;
    step(1);
    irq_ack = 1'b0; irq_eoi = 1'b0;
    chk("t6_insvc", in_service, 3'b010);
    step(1);
    chk("t6_insvc_held", in_service, 3'b010);
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    irq_eoi = 1'b1;
    step(1);
    irq_eoi = 1'b0;
    chk("t6_insvc_clr", in_service, 0);
    step(2);
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    step(3);
    chk("t6_idle_ack", irq_req, 0);
    chk("t6_terr_sticky", timeout_err, 1);

    // Asynchronous reset in the middle of a request
    irq2_in = 1'b1;
    step(2);
    irq2_in = 1'b0;
    step(3);
    chk("t7_req", irq_req, 1);
    #2;
    RST = 1'b1;
    #1;
    chk("t7_req_rst", irq_req, 0);
    chk("t7_pend_rst", pending, 0);
    chk("t7_insvc_rst", in_service, 0);
    chk("t7_terr_rst", timeout_err, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    step(8);
    chk("t7_quiet_req", irq_req, 0);
    chk("t7_quiet_pend", pending, 0);
    irq0_in = 1'b1;
    step(2);
    irq0_in = 1'b0;
    step(2);
    chk("t7_new_req", irq_req, 1);
    chk("t7_new_vec", irq_vec, 0);
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    irq_eoi = 1'b1;
    step(1);
    irq_eoi = 1'b0;
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/espic_irq_dispatch.md
Name: espic_irq_dispatch

Overview:
- Per-node interrupt dispatcher sitting directly downstream of the ESPIC interrupt generator; one instance per CPU node.
- Captures the ESPIC pulse-style outputs (periodic IRQ0, mutex-routed IRQ1, command-raised IRQ2) as sticky pending bits.
- Arbitrates pending bits by fixed priority and presents one request plus vector to the node CPU.
- Runs a request/acknowledge/end-of-interrupt handshake, with acknowledge timeout and lost-event reporting.

Parameters:
- NODE_ID, 0, selects which bit of irq1_mutex_in belongs to this node (bit NODE_ID).
- ACK_TIMEOUT, 1000, cycles to hold irq_req without irq_ack before abandoning the request (valid range 1..2^16-1).

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  asynchronous active-high reset.
- irq0_in  input  1  ESPIC out_node_IRQ0 (level pulse, multi-cycle).
- irq1_mutex_in  input  2  ESPIC out_mutex_IRQ1; only bit NODE_ID is used.
- irq2_in  input  1  ESPIC out_IRQ2_nodeN for this node.
- irq_ack  input  1  CPU acknowledge, single-cycle pulse.
- irq_eoi  input  1  CPU end-of-interrupt, single-cycle pulse.
- irq_req  output  1  interrupt request to CPU.
- irq_vec  output  2  vector of the current request: 0=IRQ0, 1=IRQ1, 2=IRQ2, 3 never driven.
- pending  output  3  sticky pending bits; [0]=IRQ0, [1]=IRQ1, [2]=IRQ2.
- in_service  output  3  one-hot source currently in service, 0 when none.
- overflow  output  1  one-cycle pulse when a source edge arrives while that source is already pending.
- timeout_err  output  1  sticky flag, set on acknowledge timeout, cleared only by RST.

Behaviour:
- Reset (async, RST=1): every output is 0, FSM goes to IDLE, synchronizers and counters are 0.
- Input capture:
  - Each of the 3 sources passes through a 2-flop synchronizer, then a rising-edge detector.
  - An input rising at cycle N produces an internal edge pulse at cycle N+2 and pending=1 visible at N+3.
  - A source held high for many cycles counts as exactly one event.
- Pending update, per bit each cycle:
  - An edge sets the bit.
  - Clear-on-ack clears the bit.
  - If edge and clear coincide, set wins and overflow is not pulsed.
  - An edge on a bit that is already 1 and not being cleared pulses overflow for 1 cycle; the bit stays 1.
- Priority (fixed): IRQ0 > IRQ1 > IRQ2. There is no preemption.
- FSM states:
  - IDLE: if pending!=0, latch irq_vec = index of highest-priority pending bit, clear the timeout counter, go to REQ next cycle. Otherwise stay in IDLE.
  - REQ: irq_req=1 and irq_vec is stable for the whole state.
    - irq_ack=1: clear pending[irq_vec], set in_service one-hot at irq_vec, go to SERVICE (irq_req=0 next cycle).
    - Otherwise the counter increments. When it reaches ACK_TIMEOUT, drop irq_req, set timeout_err, keep the pending bit, and go to IDLE.
    - From IDLE the FSM re-arbitrates on the following cycle, so there is a minimum 1-cycle irq_req gap.
  - SERVICE: irq_req=0. New edges still set pending.
    - irq_eoi=1: clear in_service, go to IDLE. The next request can assert 2 cycles after irq_eoi.
- Ignored events:
  - irq_ack outside REQ.
  - irq_eoi outside SERVICE.
  - irq_ack and irq_eoi asserted together in REQ: handled as ack only.
- Timeout counter is 16 bits and never wraps; it is bounded by ACK_TIMEOUT.
- Reset mid-operation drops irq_req, pending and in_service immediately, with no handshake completion.

Test Plan:
- Single IRQ2: irq2_in high 5 cycles from cycle 10 -> pending=3'b100 at cycle 13, irq_req=1 with irq_vec=2 at 14; irq_ack at 20 -> pending=0, in_service=3'b100 at 21; irq_eoi at 30 -> in_service=0 at 31, no further irq_req.
- Priority: irq2_in and irq0_in both rise at cycle 10 -> irq_vec=0 first. After ack and eoi of IRQ0, a second request follows with irq_vec=2.
- Node select: NODE_ID=1, irq1_mutex_in=2'b01 -> no pending change. irq1_mutex_in=2'b10 -> pending[1]=1, irq_vec=1.
- Overflow and coincidence:
  - Second irq0_in rise while pending[0]=1 and in REQ without ack -> overflow pulses for exactly 1 cycle.
  - IRQ0 edge on the same cycle as the IRQ0 ack -> pending[0] stays 1, no overflow.
- Timeout: ACK_TIMEOUT=8, no ack -> irq_req high 8 cycles, drops, timeout_err=1 stays set, pending bit kept, irq_req reasserts after a 1-cycle gap.
- Async reset: assert RST mid-REQ between clock edges -> irq_req, pending, in_service and timeout_err all 0 immediately; after release, only new input edges cause requests.
